// File: rtl/bf_console.sv
// Text console sink: queues core print bytes, renders {ATTR,char} cells into video RAM, tracks cursor.
// Latency: print at edge N -> pop at N+1 -> vwe during cycle after N+2; 2 cycles per printable byte.
// Backpressure: none upstream; a strobe while full is dropped and sets sticky overflow. BF_CONSOLE_SCROLL_EN enables scroll.
module bf_console #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 25,
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] ATTR       = 8'h07
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        print,
    input  logic [7:0]  data,
    output logic [10:0] vaddr,
    output logic [15:0] vdout,
    output logic        vwe,
    input  logic [15:0] vdin,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy,
    output logic        full,
    output logic        overflow
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [10:0]         COLS_A   = 11'(COLS);
    localparam logic [10:0]         CLR_LAST = 11'(COLS - 1);
    localparam logic [6:0]          X_LAST   = 7'(COLS - 1);
    localparam logic [4:0]          Y_LAST   = 5'(ROWS - 1);
    localparam logic [15:0]         BLANK    = {ATTR, 8'h20};
`ifdef BF_CONSOLE_SCROLL_EN
    localparam logic [10:0]         SCR_LAST = 11'((ROWS - 1) * COLS - 1);
    localparam logic [10:0]         CLR_BASE = 11'((ROWS - 1) * COLS);
`endif

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
`ifdef BF_CONSOLE_SCROLL_EN
        SCROLL_RD,
        SCROLL_WR,
`endif
        CLEAR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            ch_q, ch_d;
    logic [6:0]            cur_x_q, cur_x_d;
    logic [4:0]            cur_y_q, cur_y_d;
    logic [10:0]           vaddr_q, vaddr_d;
    logic [15:0]           vdout_q, vdout_d;
    logic                  vwe_q, vwe_d;
    logic [10:0]           ptr_q, ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            mem_q [DEPTH];

    logic                  fifo_full, fifo_empty, push, pop;
    logic [10:0]           cell_addr;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    // Acceptance looks only at the registered count, never at a same-cycle pop.
    assign push       = print && !fifo_full;
    assign cell_addr  = 11'(cur_y_q) * COLS_A + 11'(cur_x_q);

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        vaddr_d    = vaddr_q;
        vdout_d    = vdout_q;
        vwe_d      = 1'b0;
        ptr_d      = ptr_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    ch_d    = mem_q[rd_ptr_q];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                case (ch_q)
                    8'h0A: begin
                        cur_x_d = '0;
                        if (cur_y_q < Y_LAST) begin
                            cur_y_d = cur_y_q + 5'd1;
                        end else begin
                            ptr_d   = '0;
`ifdef BF_CONSOLE_SCROLL_EN
                            vaddr_d = COLS_A;
                            state_d = SCROLL_RD;
`else
                            cur_y_d = '0;
                            vaddr_d = '0;
                            vdout_d = BLANK;
                            vwe_d   = 1'b1;
                            state_d = CLEAR;
`endif
                        end
                    end
                    8'h0D: cur_x_d = '0;
                    8'h08: begin
                        if (cur_x_q != '0) begin
                            cur_x_d = cur_x_q - 7'd1;
                            vaddr_d = cell_addr - 11'd1;
                            vdout_d = BLANK;
                            vwe_d   = 1'b1;
                        end
                    end
                    default: begin
                        vaddr_d = cell_addr;
                        vdout_d = {ATTR, ch_q};
                        vwe_d   = 1'b1;
                        if (cur_x_q < X_LAST) begin
                            cur_x_d = cur_x_q + 7'd1;
                        end else if (cur_y_q < Y_LAST) begin
                            cur_x_d = '0;
                            cur_y_d = cur_y_q + 5'd1;
                        end else begin
                            // Wrap on the last row: re-enter EXEC as a newline so the
                            // scroll/clear never collides with this cell write.
                            cur_x_d = '0;
                            ch_d    = 8'h0A;
                            state_d = EXEC;
                        end
                    end
                endcase
            end
`ifdef BF_CONSOLE_SCROLL_EN
            SCROLL_RD: begin
                vaddr_d = ptr_q;
                vwe_d   = 1'b1;
                state_d = SCROLL_WR;
            end
            SCROLL_WR: begin
                if (ptr_q == SCR_LAST) begin
                    ptr_d   = '0;
                    vaddr_d = CLR_BASE;
                    vdout_d = BLANK;
                    vwe_d   = 1'b1;
                    state_d = CLEAR;
                end else begin
                    ptr_d   = ptr_q + 11'd1;
                    vaddr_d = ptr_q + 11'd1 + COLS_A;
                    state_d = SCROLL_RD;
                end
            end
`endif
            CLEAR: begin
                if (ptr_q == CLR_LAST) begin
                    state_d = IDLE;
                end else begin
                    ptr_d   = ptr_q + 11'd1;
                    vaddr_d = vaddr_q + 11'd1;
                    vdout_d = BLANK;
                    vwe_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q | (print & fifo_full);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            vaddr_q    <= '0;
            vdout_q    <= '0;
            vwe_q      <= 1'b0;
            ptr_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            vaddr_q    <= vaddr_d;
            vdout_q    <= vdout_d;
            vwe_q      <= vwe_d;
            ptr_q      <= ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    assign vaddr    = vaddr_q;
    assign vwe      = vwe_q;
    assign cur_x    = cur_x_q;
    assign cur_y    = cur_y_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign full     = fifo_full;
    assign overflow = overflow_q;

`ifdef BF_CONSOLE_SCROLL_EN
    // Read data arrives the cycle after the read address, so it is forwarded straight to the write.
    assign vdout = (state_q == SCROLL_WR) ? vdin : vdout_q;
`else
    logic unused_vdin;
    assign unused_vdin = ^vdin;
    assign vdout       = vdout_q;
`endif

endmodule

// File: tb/tb_bf_console.sv
// Bench for bf_console: video RAM model, write scoreboard, vector table plus multi-cycle sequences.
module tb_bf_console;

    logic        clock = 1'b0;
    logic        reset;
    logic        print;
    logic [7:0]  data;
    logic [10:0] vaddr;
    logic [15:0] vdout;
    logic        vwe;
    logic [15:0] vdin;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;
    logic        full;
    logic        overflow;
    logic        preload;

    bf_console dut (
        .clock   (clock),
        .reset   (reset),
        .print   (print),
        .data    (data),
        .vaddr   (vaddr),
        .vdout   (vdout),
        .vwe     (vwe),
        .vdin    (vdin),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .busy    (busy),
        .full    (full),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    logic [15:0] ram [0:2047];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) ram[i] <= 16'(i);
        end else begin
            if (vwe) ram[vaddr] <= vdout;
            vdin <= ram[vaddr];
        end
    end

    typedef struct packed {
        logic [10:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q [$];

    int checks = 0;
    int passes = 0;
    int ty     = 0;

    always @(negedge clock) begin
        if (!reset && vwe) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: addr %0d data %h, nothing expected", vaddr, vdout);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (vaddr === e.a && vdout === e.d) passes++;
                else $display("FAIL vram_write: got addr %0d data %h, want addr %0d data %h",
                              vaddr, vdout, e.a, e.d);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic push_wr(input int a, input logic [15:0] d);
        exp_q.push_back(wr_t'{a: 11'(a), d: d});
    endtask

    task automatic print_byte(input logic [7:0] b);
        @(posedge clock); #1;
        print = 1'b1;
        data  = b;
        @(posedge clock); #1;
        print = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output int cyc);
        cyc = 0;
        while (busy && cyc < max_cyc) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
        @(negedge clock); #1;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        ty = 0;
    endtask

    task automatic goto_last_row();
        int c;
        while (ty < 24) begin
            print_byte(8'h0A);
            wait_idle(100, c);
            ty++;
        end
    endtask

    task automatic push_scroll_from_ram();
`ifdef BF_CONSOLE_SCROLL_EN
        for (int i = 0; i < 1920; i++) push_wr(i, ram[i + 80]);
        for (int i = 0; i < 80; i++) push_wr(1920 + i, 16'h0720);
`else
        for (int i = 0; i < 80; i++) push_wr(i, 16'h0720);
`endif
    endtask

    typedef struct {
        logic [7:0]  ch;
        logic        we;
        logic [10:0] a;
        logic [15:0] d;
        logic [6:0]  x;
        logic [4:0]  y;
    } vec_t;
    vec_t tbl [10];

    initial begin
        int cyc;
        int base;
        int exp_y;
`ifdef BF_CONSOLE_SCROLL_EN
        base  = 1920;
        exp_y = 24;
`else
        base  = 0;
        exp_y = 0;
`endif
        reset   = 1'b1;
        print   = 1'b0;
        data    = 8'h00;
        preload = 1'b0;

        tbl[0] = '{8'h41, 1'b1, 11'd0,  16'h0741, 7'd1, 5'd0};
        tbl[1] = '{8'h42, 1'b1, 11'd1,  16'h0742, 7'd2, 5'd0};
        tbl[2] = '{8'h43, 1'b1, 11'd2,  16'h0743, 7'd3, 5'd0};
        tbl[3] = '{8'h08, 1'b1, 11'd2,  16'h0720, 7'd2, 5'd0};
        tbl[4] = '{8'h0D, 1'b0, 11'd0,  16'h0000, 7'd0, 5'd0};
        tbl[5] = '{8'h08, 1'b0, 11'd0,  16'h0000, 7'd0, 5'd0};
        tbl[6] = '{8'h0A, 1'b0, 11'd0,  16'h0000, 7'd0, 5'd1};
        tbl[7] = '{8'h44, 1'b1, 11'd80, 16'h0744, 7'd1, 5'd1};
        tbl[8] = '{8'h08, 1'b1, 11'd80, 16'h0720, 7'd0, 5'd1};
        tbl[9] = '{8'h0A, 1'b0, 11'd0,  16'h0000, 7'd0, 5'd2};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_vaddr", 32'(vaddr), 32'd0);
        chk("rst_vdout", 32'(vdout), 32'd0);
        chk("rst_vwe", 32'(vwe), 32'd0);
        chk("rst_cur_x", 32'(cur_x), 32'd0);
        chk("rst_cur_y", 32'(cur_y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        // First-byte latency: strobe sampled at edge N, write visible after edge N+2.
        push_wr(0, 16'h0741);
        @(posedge clock); #1;
        print = 1'b1;
        data  = 8'h41;
        @(posedge clock); #1;
        print = 1'b0;
        chk("lat_busy_n", 32'(busy), 32'd1);
        @(posedge clock); #1;
        chk("lat_vwe_n1", 32'(vwe), 32'd0);
        @(posedge clock); #1;
        chk("lat_vwe_n2", 32'(vwe), 32'd1);
        chk("lat_vaddr_n2", 32'(vaddr), 32'd0);
        chk("lat_vdout_n2", 32'(vdout), 32'h0741);
        chk("lat_cur_x_n2", 32'(cur_x), 32'd1);
        wait_idle(100, cyc);
        chk("lat_sb_drain", 32'(exp_q.size()), 32'd0);
        chk("lat_cur_x", 32'(cur_x), 32'd1);
        chk("lat_cur_y", 32'(cur_y), 32'd0);
        chk("lat_busy", 32'(busy), 32'd0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].we) push_wr(int'(tbl[i].a), tbl[i].d);
            print_byte(tbl[i].ch);
            wait_idle(100, cyc);
            chk($sformatf("tbl%0d_sb_drain", i), 32'(exp_q.size()), 32'd0);
            chk($sformatf("tbl%0d_cur_x", i), 32'(cur_x), 32'(tbl[i].x));
            chk($sformatf("tbl%0d_cur_y", i), 32'(cur_y), 32'(tbl[i].y));
        end

        // A full row at the sustained rate of one strobe every two cycles.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            push_wr(i, 16'h0742);
            @(posedge clock); #1;
            print = 1'b1;
            data  = 8'h42;
            @(posedge clock); #1;
            print = 1'b0;
        end
        wait_idle(200, cyc);
        chk("row_sb_drain", 32'(exp_q.size()), 32'd0);
        chk("row_overflow", 32'(overflow), 32'd0);
        chk("row_cur_x", 32'(cur_x), 32'd0);
        chk("row_cur_y", 32'(cur_y), 32'd1);

        // Newline at the last row with cursor at (5,24) over a preloaded screen.
        do_reset();
        goto_last_row();
        for (int i = 0; i < 5; i++) begin
            push_wr(1920 + i, 16'h0778);
            print_byte(8'h78);
            wait_idle(100, cyc);
        end
        chk("pos_cur_x", 32'(cur_x), 32'd5);
        chk("pos_cur_y", 32'(cur_y), 32'd24);
        chk("pos_sb_drain", 32'(exp_q.size()), 32'd0);
        @(posedge clock); #1;
        preload = 1'b1;
        @(posedge clock); #1;
        preload = 1'b0;
`ifdef BF_CONSOLE_SCROLL_EN
        for (int i = 0; i < 1920; i++) push_wr(i, 16'(i + 80));
        for (int i = 0; i < 80; i++) push_wr(1920 + i, 16'h0720);
`else
        for (int i = 0; i < 80; i++) push_wr(i, 16'h0720);
`endif
        print_byte(8'h0A);
        wait_idle(6000, cyc);
`ifdef BF_CONSOLE_SCROLL_EN
        chk("scroll_busy_long", 32'(cyc >= 3920), 32'd1);
`else
        chk("clear_busy_long", 32'(cyc >= 80), 32'd1);
        ty = 0;
`endif
        chk("scroll_sb_drain", 32'(exp_q.size()), 32'd0);
        chk("scroll_cur_x", 32'(cur_x), 32'd0);
        chk("scroll_cur_y", 32'(cur_y), 32'(exp_y));

        // Seventeen strobes while the screen is busy scrolling/clearing.
        goto_last_row();
        push_scroll_from_ram();
        for (int k = 0; k < 16; k++) push_wr(base + k, {8'h07, 8'(8'h61 + k)});
        print_byte(8'h0A);
        repeat (10) @(posedge clock);
        for (int k = 0; k < 17; k++) begin
            #1;
            print = 1'b1;
            data  = 8'(8'h61 + k);
            @(posedge clock); #1;
            print = 1'b0;
            if (k == 14) chk("ovf_full_at15", 32'(full), 32'd0);
            if (k == 15) chk("ovf_full_at16", 32'(full), 32'd1);
            if (k == 15) chk("ovf_clear_at16", 32'(overflow), 32'd0);
            if (k == 16) chk("ovf_set_at17", 32'(overflow), 32'd1);
        end
        wait_idle(6000, cyc);
`ifndef BF_CONSOLE_SCROLL_EN
        ty = 0;
`endif
        chk("ovf_sb_drain", 32'(exp_q.size()), 32'd0);
        chk("ovf_cur_x", 32'(cur_x), 32'd16);
        chk("ovf_cur_y", 32'(cur_y), 32'(exp_y));
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_full_after", 32'(full), 32'd0);

        // Reset in the middle of a scroll/clear.
        goto_last_row();
        push_scroll_from_ram();
        print_byte(8'h0A);
        repeat (40) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_rst_vwe", 32'(vwe), 32'd0);
        chk("mid_rst_vaddr", 32'(vaddr), 32'd0);
        chk("mid_rst_vdout", 32'(vdout), 32'd0);
        chk("mid_rst_cur_x", 32'(cur_x), 32'd0);
        chk("mid_rst_cur_y", 32'(cur_y), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        ty = 0;
        @(posedge clock); #1;
        chk("post_rst_vwe", 32'(vwe), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        push_wr(0, 16'h0741);
        print_byte(8'h41);
        wait_idle(100, cyc);
        chk("post_rst_sb_drain", 32'(exp_q.size()), 32'd0);
        chk("post_rst_cur_x", 32'(cur_x), 32'd1);
        chk("post_rst_cur_y", 32'(cur_y), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bf_console.md
# bf_console

Text-console sink directly downstream of the brainfuck core. It captures the core's one-cycle `print` strobes and output bytes into a small FIFO, because the core has no backpressure. It then interprets each byte as a character or control code and writes `{attr, char}` cells into an external text-mode video RAM. It tracks the cursor and handles line wrap, CR/LF, backspace and hardware scroll.

## Interface

Parameters:
- `COLS`, 80: characters per row.
- `ROWS`, 25: rows per screen. `COLS*ROWS` ≤ 2048.
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries.
- `ATTR`, 8'h07: attribute byte written with every cell.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `print` in 1: one-cycle strobe from the core; push `data`.
- `data` in 8: byte from the core's `out`.
- `vaddr` out 11: video cell address, `y*COLS + x`.
- `vdout` out 16: cell write data, `{ATTR, char}`.
- `vwe` out 1: video write enable, one cycle per cell.
- `vdin` in 16: video read data; valid the cycle after `vaddr` is presented.
- `cur_x` out 7: cursor column.
- `cur_y` out 5: cursor row.
- `busy` out 1: state ≠ IDLE or FIFO not empty.
- `full` out 1: FIFO holds 2^DEPTH_LOG2 entries.
- `overflow` out 1: sticky; a strobe arrived while full.

## Operation

- **FIFO:**
  - Push when `print` is high and the FIFO is not full at the start of the cycle. An acceptance check does not credit a same-cycle pop.
  - A push while full drops the byte and sets `overflow`. Only `reset` clears `overflow`.
  - Simultaneous push and pop when not full leaves the count unchanged.
- **States:** IDLE, EXEC, SCROLL_RD, SCROLL_WR, CLEAR.
- **IDLE:** if the FIFO is non-empty, pop into `ch` and go to EXEC.
- **EXEC:** decode `ch`.
  - 0x0A LF: `cur_x`=0. If `cur_y`<ROWS-1, `cur_y`+1 → IDLE. Else → scroll.
  - 0x0D CR: `cur_x`=0 → IDLE. No write.
  - 0x08 BS: if `cur_x`>0, `cur_x`-1 and write `{ATTR,8'h20}` at the new position. At `cur_x`=0 nothing happens. → IDLE.
  - Any other byte: write `{ATTR,ch}` at `(cur_x,cur_y)`.
    - If `cur_x`<COLS-1, `cur_x`+1.
    - Else perform the LF action, including scroll at the last row.
- **Scroll:** pointer `p` runs from 0 to (ROWS-1)*COLS-1.
  - SCROLL_RD drives `vaddr`=p+COLS.
  - SCROLL_WR drives `vaddr`=p, `vdout`=`vdin`, `vwe`=1, then p+1.
  - After the last cell, go to CLEAR.
  - CLEAR writes `{ATTR,8'h20}` to each of the COLS cells of row ROWS-1, one per cycle, then → IDLE.
  - `cur_y` stays at ROWS-1.
- **Arithmetic:** all cursor and address arithmetic is unsigned. The address is computed as `cur_y*COLS+cur_x` and truncated to 11 bits.
- **Reset mid-operation:** the state machine returns to IDLE at once and no further `vwe` is issued. A partially scrolled screen is left as is. The FIFO empties.

## Timing

- Reset values:
  - `vaddr`=0, `vdout`=0, `vwe`=0.
  - `cur_x`=0, `cur_y`=0.
  - `busy`=0, `full`=0, `overflow`=0.
  - FIFO empty, state IDLE.
- **Latency:** with the block idle and the FIFO empty, a `print` at edge N shows as FIFO non-empty after N. The pop happens at N+1. `vwe` is high during the cycle after edge N+2. The cursor updates at the same edge as the write is registered.
- Sustained throughput is 2 cycles per printable character. The core can push at most one byte per cycle.
- A full scroll takes 2*(ROWS-1)*COLS + COLS cycles. At default parameters this is 3920 cycles.
- `vwe` is never high for more than one consecutive cycle outside CLEAR.
- `full` and `overflow` are registered and update one edge after the causing push.

## Configuration

- `BF_CONSOLE_SCROLL_EN` defined: scroll behaviour as above.
- Undefined:
  - SCROLL_RD, SCROLL_WR and CLEAR are not compiled, and `vdin` is ignored.
  - A newline at the last row sets `cur_y`=0 and clears row 0 in COLS cycles.
  - `cur_x`=0.

## Test plan

- Reset, then `print` with 0x41: one `vwe` with `vaddr`=0 and `vdout`=16'h0741, two cycles after the strobe. Then `cur_x`=1, `cur_y`=0, `busy`=0.
- Print 80 × 0x42 back-to-back: writes at addresses 0..79, no drops, `overflow`=0. Final cursor is (0,1).
- Print 0x41 0x42 0x43 0x08: last write is `vaddr`=2, 16'h0720, with `cur_x`=2. BS at `cur_x`=0 produces no `vwe` and the cursor is unchanged.
- Scroll:
  - Preload the RAM model with cell i = i. Put the cursor at (5,24), then print 0x0A.
  - Required: writes to 0..1919 with data i+80, then 80 writes of 16'h0720 at 1920..1999.
  - `busy` stays high for 3920+ cycles and ends with the cursor at (0,24).
  - With `BF_CONSOLE_SCROLL_EN` undefined, the same LF clears 0..79 and leaves the cursor at (0,0).
- During a scroll, strobe 17 bytes: `full`=1 after 16 pushes and `overflow`=1. After the scroll, exactly 16 characters are written.
- Assert `reset` mid-scroll: `vwe`=0 from the next cycle and all outputs return to their reset values. A subsequent 0x41 writes to address 0.
